// File: rtl/bmp280_sequencer.sv
// BMP280 transaction sequencer: chip-ID check, config/ctrl_meas writes, then periodic
// six-byte raw pressure/temperature bursts driven through a 16-bit SPI master.
module bmp280_sequencer #(
  parameter int unsigned SAMPLE_CYCLES  = 5000000,
  parameter int unsigned POWERUP_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  CTRL_MEAS_VAL  = 8'h27,
  parameter logic [7:0]  CONFIG_VAL     = 8'h00,
  parameter logic [7:0]  CHIP_ID        = 8'h58
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        spi_enable,
  output logic [15:0] spi_tx,
  input  logic [15:0] spi_rx,
  input  logic        spi_busy,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic        data_valid,
  output logic        id_ok,
  output logic        spi_error
);

  localparam int PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_RD_ID, S_WR_CFG, S_WR_CTRL, S_SAMPLE_WAIT, S_RD_BURST, S_PUBLISH
  } state_t;

  typedef enum logic [1:0] {
    T_ISSUE, T_WAIT_BUSY_HI, T_WAIT_BUSY_LO, T_DONE
  } txn_t;

  state_t            r_state, w_state_nxt;
  txn_t              r_txn, w_txn_nxt;
  logic [PWR_W-1:0]  r_pwr_cnt;
  logic [SMP_W-1:0]  r_smp_cnt;
  logic [1:0]        r_hi_cnt;
  logic [TMO_W-1:0]  r_busy_cnt;
  logic [2:0]        r_byte_idx;
  logic [5:0][7:0]   r_shadow;
  logic [7:0]        r_rx_byte;
  logic              r_spi_enable;
  logic [15:0]       r_spi_tx;
  logic [19:0]       r_press, r_temp;
  logic              r_data_valid, r_id_ok, r_spi_error;

  logic              w_in_txn, w_issue, w_timeout, w_done, w_id_match;
  logic [15:0]       w_cmd;
  logic              w_unused;

  assign w_unused   = ^{spi_rx[15:8], r_shadow[2][3:0], r_shadow[5][3:0]};
  assign w_id_match = (r_rx_byte == CHIP_ID);

  always_comb begin
    w_state_nxt = r_state;
    w_txn_nxt   = r_txn;
    w_in_txn    = 1'b0;
    w_issue     = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    w_cmd       = 16'h0000;

    case (r_state)
      S_RD_ID:    begin w_in_txn = 1'b1; w_cmd = 16'hD000; end
      S_WR_CFG:   begin w_in_txn = 1'b1; w_cmd = {8'h75, CONFIG_VAL}; end
      S_WR_CTRL:  begin w_in_txn = 1'b1; w_cmd = {8'h74, CTRL_MEAS_VAL}; end
      S_RD_BURST: begin w_in_txn = 1'b1; w_cmd = {8'hF7 + {5'd0, r_byte_idx}, 8'h00}; end
      default:    begin w_in_txn = 1'b0; w_cmd = 16'h0000; end
    endcase

    // Per-transaction handshake; only runs while the main FSM owns a transaction
    if (w_in_txn) begin
      case (r_txn)
        T_ISSUE: begin
          if (!spi_busy) begin
            w_issue   = 1'b1;
            w_txn_nxt = T_WAIT_BUSY_HI;
          end
        end
        T_WAIT_BUSY_HI: begin
          if (spi_busy)            w_txn_nxt = T_WAIT_BUSY_LO;
          else if (r_hi_cnt == 2'd3) w_timeout = 1'b1;
        end
        T_WAIT_BUSY_LO: begin
          if (!spi_busy)                  w_txn_nxt = T_DONE;
          else if (r_busy_cnt >= TMO_MAX) w_timeout = 1'b1;
        end
        default: begin
          w_done    = 1'b1;
          w_txn_nxt = T_ISSUE;
        end
      endcase
    end

    case (r_state)
      S_PWR_WAIT:    if (r_pwr_cnt == PWR_LAST) w_state_nxt = S_RD_ID;
      S_RD_ID:       if (w_done) w_state_nxt = w_id_match ? S_WR_CFG : S_PWR_WAIT;
      S_WR_CFG:      if (w_done) w_state_nxt = S_WR_CTRL;
      S_WR_CTRL:     if (w_done) w_state_nxt = S_SAMPLE_WAIT;
      S_SAMPLE_WAIT: if (r_smp_cnt == '0) w_state_nxt = S_RD_BURST;
      S_RD_BURST:    if (w_done && (r_byte_idx == 3'd5)) w_state_nxt = S_PUBLISH;
      S_PUBLISH:     w_state_nxt = S_SAMPLE_WAIT;
      default:       w_state_nxt = S_PWR_WAIT;
    endcase

    // A stuck master abandons everything and forces full re-initialisation
    if (w_timeout) begin
      w_state_nxt = S_PWR_WAIT;
      w_txn_nxt   = T_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_PWR_WAIT;
      r_txn      <= T_ISSUE;
      r_pwr_cnt  <= '0;
      r_smp_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_txn     <= w_txn_nxt;
      r_pwr_cnt <= ((r_state == S_PWR_WAIT) && (w_state_nxt == S_PWR_WAIT)) ?
                   r_pwr_cnt + 1'b1 : '0;
      if ((w_state_nxt == S_SAMPLE_WAIT) && (r_state != S_SAMPLE_WAIT))
        r_smp_cnt <= SMP_LAST;
      else if ((r_state == S_SAMPLE_WAIT) && (r_smp_cnt != '0))
        r_smp_cnt <= r_smp_cnt - 1'b1;
      r_hi_cnt <= (w_in_txn && (r_txn == T_WAIT_BUSY_HI) && !spi_busy && !w_timeout) ?
                  r_hi_cnt + 1'b1 : '0;
      // The cycle busy is first seen high already counts as one busy-high cycle
      if (w_in_txn && (r_txn == T_WAIT_BUSY_HI) && spi_busy)
        r_busy_cnt <= TMO_W'(1);
      else if (w_in_txn && (r_txn == T_WAIT_BUSY_LO) && spi_busy && !w_timeout)
        r_busy_cnt <= r_busy_cnt + 1'b1;
      else
        r_busy_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spi_enable <= 1'b0;
      r_spi_tx     <= 16'h0000;
      r_rx_byte    <= 8'h00;
      r_byte_idx   <= 3'd0;
      r_shadow     <= '0;
    end else begin
      r_spi_enable <= w_issue;
      if (w_issue) r_spi_tx <= w_cmd;
      if (w_in_txn && (r_txn == T_WAIT_BUSY_LO) && !spi_busy)
        r_rx_byte <= spi_rx[7:0];
      if (w_timeout || (r_state == S_PWR_WAIT)) begin
        r_byte_idx <= 3'd0;
      end else if ((r_state == S_RD_BURST) && w_done) begin
        r_shadow[r_byte_idx] <= r_rx_byte;
        r_byte_idx           <= (r_byte_idx == 3'd5) ? 3'd0 : r_byte_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press      <= 20'h00000;
      r_temp       <= 20'h00000;
      r_data_valid <= 1'b0;
      r_id_ok      <= 1'b0;
      r_spi_error  <= 1'b0;
    end else begin
      r_data_valid <= (r_state == S_PUBLISH);
      if (r_state == S_PUBLISH) begin
        r_press <= {r_shadow[0], r_shadow[1], r_shadow[2][7:4]};
        r_temp  <= {r_shadow[3], r_shadow[4], r_shadow[5][7:4]};
      end
      if ((r_state == S_RD_ID) && w_done && w_id_match)
        r_id_ok <= 1'b1;
      if (w_timeout || ((r_state == S_RD_ID) && w_done && !w_id_match))
        r_spi_error <= 1'b1;
    end
  end

  assign spi_enable = r_spi_enable;
  assign spi_tx     = r_spi_tx;
  assign press_raw  = r_press;
  assign temp_raw   = r_temp;
  assign data_valid = r_data_valid;
  assign id_ok      = r_id_ok;
  assign spi_error  = r_spi_error;

endmodule

// File: tb/tb_bmp280_sequencer.sv
// Directed bench for bmp280_sequencer with a behavioural SPI master model.
module tb_bmp280_sequencer;

  localparam int POW = 20;
  localparam int SMP = 200;
  localparam int TMO = 16;
  localparam int BL  = 3;          // normal busy-high length
  localparam int HL  = TMO + 1;    // busy-high length of a hung read
  localparam int TXN = BL + 3;     // issue-to-issue spacing of one transaction

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_enable;
  logic [15:0] spi_tx;
  logic [15:0] spi_rx = 16'h0000;
  logic        spi_busy = 1'b0;
  logic [19:0] press_raw, temp_raw;
  logic        data_valid, id_ok, spi_error;

  int errors = 0;
  int checks = 0;

  logic [15:0] tx_log[$];
  int          tx_cyc[$];
  int          dv_cyc[$];
  int          cyc = 0;
  int          dv_count = 0;
  int          en_busy = 0;
  int          dv_no_id = 0;
  int          bcnt = 0;
  logic [7:0]  cur_addr = 8'h00;
  logic [7:0]  id_resp = 8'h58;
  logic [7:0]  burst[6];
  bit          hang_en = 1'b0;

  bmp280_sequencer #(
    .SAMPLE_CYCLES(SMP), .POWERUP_CYCLES(POW), .TIMEOUT_CYCLES(TMO),
    .CTRL_MEAS_VAL(8'h27), .CONFIG_VAL(8'h00), .CHIP_ID(8'h58)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi_enable(spi_enable), .spi_tx(spi_tx),
    .spi_rx(spi_rx), .spi_busy(spi_busy), .press_raw(press_raw), .temp_raw(temp_raw),
    .data_valid(data_valid), .id_ok(id_ok), .spi_error(spi_error)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] resp(input logic [7:0] addr);
    if (addr == 8'hD0) return id_resp;
    if (addr >= 8'hF7 && addr <= 8'hFC) return burst[int'(addr - 8'hF7)];
    return 8'h00;
  endfunction

  // SPI master model: acts on falling edges so the DUT sees stable inputs at posedge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      spi_busy = 1'b0;
      bcnt = 0;
    end else begin
      if (spi_enable) begin
        if (spi_busy) en_busy++;
        tx_log.push_back(spi_tx);
        tx_cyc.push_back(cyc);
        cur_addr = spi_tx[15:8];
        spi_busy = 1'b1;
        bcnt = (hang_en && cur_addr == 8'hF9) ? HL : BL;
      end else if (spi_busy) begin
        bcnt--;
        if (bcnt == 0) begin
          spi_busy = 1'b0;
          spi_rx = {8'hA5, resp(cur_addr)};
        end
      end
      if (data_valid) begin
        dv_count++;
        dv_cyc.push_back(cyc);
        if (!id_ok) dv_no_id++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    hang_en = 1'b0;
    id_resp = 8'h58;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({spi_enable, spi_tx, press_raw, temp_raw, data_valid, id_ok, spi_error} !== 60'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b tx=%h p=%h t=%h dv=%b id=%b err=%b required all 0",
               spi_enable, spi_tx, press_raw, temp_raw, data_valid, id_ok, spi_error);
    end
    tx_log.delete(); tx_cyc.delete(); dv_cyc.delete(); dv_count = 0;
    reset_n = 1'b1;
    n = 0;
    while (tx_log.size() == 0 && n < POW + 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n !== POW + 1) begin
      errors++;
      $display("FAIL powerup_delay: first enable after %0d cycles, required %0d", n, POW + 1);
    end
  endtask

  task automatic test_bringup();
    logic [15:0] exp_tx[3];
    int n = 0;
    exp_tx[0] = 16'hD000; exp_tx[1] = 16'h7500; exp_tx[2] = 16'h7427;
    while (tx_log.size() < 3 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL bringup_tx%0d: got %h required %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, exp_tx[i]);
      end
    end
    checks++;
    if (id_ok !== 1'b1 || spi_error !== 1'b0) begin
      errors++;
      $display("FAIL bringup_flags: got id_ok=%b spi_error=%b required 1 0", id_ok, spi_error);
    end
  endtask

  task automatic test_sample();
    int n = 0;
    burst[0] = 8'h65; burst[1] = 8'h5A; burst[2] = 8'hC0;
    burst[3] = 8'h7E; burst[4] = 8'hED; burst[5] = 8'h00;
    while (dv_count < 1 && n < SMP + 300) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (dv_count !== 1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL sample_strobe: got count=%0d dv=%b required 1 1", dv_count, data_valid);
    end
    checks++;
    if (press_raw !== 20'h655AC || temp_raw !== 20'h7EED0) begin
      errors++;
      $display("FAIL sample_values: got p=%h t=%h required 655ac 7eed0", press_raw, temp_raw);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (3 + i >= tx_log.size() || tx_log[3 + i] !== {8'hF7 + 8'(i), 8'h00}) begin
        errors++;
        $display("FAIL burst_tx%0d: got %h required %h", i,
                 (3 + i < tx_log.size()) ? tx_log[3 + i] : 16'hxxxx, {8'hF7 + 8'(i), 8'h00});
      end
    end
    checks++;
    if (dv_cyc.size() < 1 || tx_cyc.size() < 3 ||
        dv_cyc[0] - tx_cyc[2] !== BL + 2 + SMP + 6 * TXN + 1) begin
      errors++;
      $display("FAIL first_period: got %0d required %0d",
               (dv_cyc.size() > 0 && tx_cyc.size() > 2) ? dv_cyc[0] - tx_cyc[2] : -1,
               BL + 2 + SMP + 6 * TXN + 1);
    end
    @(negedge clk); #1;
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width: got dv=%b one cycle later required 0", data_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    burst[0] = 8'h12; burst[1] = 8'h34; burst[2] = 8'h56;
    burst[3] = 8'h78; burst[4] = 8'h9A; burst[5] = 8'hBC;
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (press_raw !== 20'h655AC || temp_raw !== 20'h7EED0) begin
      errors++;
      $display("FAIL hold_values: got p=%h t=%h required 655ac 7eed0", press_raw, temp_raw);
    end
    while (dv_count < 2 && n < SMP + 300) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (dv_count !== 2 || press_raw !== 20'h12345 || temp_raw !== 20'h789AB) begin
      errors++;
      $display("FAIL second_sample: got count=%0d p=%h t=%h required 2 12345 789ab",
               dv_count, press_raw, temp_raw);
    end
    checks++;
    if (dv_cyc.size() < 2 || dv_cyc[1] - dv_cyc[0] !== SMP + 6 * TXN + 1) begin
      errors++;
      $display("FAIL strobe_spacing: got %0d required %0d",
               (dv_cyc.size() > 1) ? dv_cyc[1] - dv_cyc[0] : -1, SMP + 6 * TXN + 1);
    end
    checks++;
    if (en_busy !== 0) begin
      errors++;
      $display("FAIL enable_while_busy: got %0d occurrences required 0", en_busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int idx;
    int base_dv = dv_count;
    hang_en = 1'b1;
    while (spi_error !== 1'b1 && n < SMP + 400) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (spi_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_error: got spi_error=%b required 1", spi_error);
    end
    idx = tx_log.size();
    checks++;
    if (idx < 1 || tx_log[idx - 1] !== 16'hF900) begin
      errors++;
      $display("FAIL timeout_last_tx: got %h required f900",
               (idx > 0) ? tx_log[idx - 1] : 16'hxxxx);
    end
    hang_en = 1'b0;
    n = 0;
    while (tx_log.size() <= idx && n < POW + 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (tx_log.size() <= idx || tx_log[idx] !== 16'hD000) begin
      errors++;
      $display("FAIL timeout_reinit: got %h required d000",
               (tx_log.size() > idx) ? tx_log[idx] : 16'hxxxx);
    end
    checks++;
    if (dv_count !== base_dv) begin
      errors++;
      $display("FAIL timeout_no_publish: got %0d strobes required %0d", dv_count, base_dv);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] exp_tx[3];
    int n = 0;
    int idx0 = tx_log.size();
    exp_tx[0] = 16'hD000; exp_tx[1] = 16'h7500; exp_tx[2] = 16'h7427;
    while (!(tx_log.size() > idx0 && tx_log[tx_log.size() - 1] == 16'hF900) && n < SMP + 400) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (tx_log.size() <= idx0 || tx_log[tx_log.size() - 1] !== 16'hF900) begin
      errors++;
      $display("FAIL midburst_reach: third burst read not issued within %0d cycles", n);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (spi_enable !== 1'b0 || spi_tx !== 16'h0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_spi: got en=%b tx=%h dv=%b required 0 0000 0",
               spi_enable, spi_tx, data_valid);
    end
    checks++;
    if (press_raw !== 20'h0 || temp_raw !== 20'h0) begin
      errors++;
      $display("FAIL midreset_data: got p=%h t=%h required 0 0", press_raw, temp_raw);
    end
    checks++;
    if (id_ok !== 1'b0 || spi_error !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got id_ok=%b spi_error=%b required 0 0", id_ok, spi_error);
    end
    repeat (3) @(negedge clk);
    #1;
    tx_log.delete(); tx_cyc.delete();
    reset_n = 1'b1;
    n = 0;
    while (tx_log.size() < 3 && n < POW + 100) begin
      @(negedge clk); #1; n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL restart_tx%0d: got %h required %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 16'hxxxx, exp_tx[i]);
      end
    end
  endtask

  task automatic test_bad_id();
    int n = 0;
    reset_n = 1'b0;
    id_resp = 8'h60;
    repeat (3) @(negedge clk);
    #1;
    tx_log.delete(); tx_cyc.delete();
    reset_n = 1'b1;
    while (spi_error !== 1'b1 && n < POW + 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (spi_error !== 1'b1 || id_ok !== 1'b0) begin
      errors++;
      $display("FAIL bad_id_flags: got spi_error=%b id_ok=%b required 1 0", spi_error, id_ok);
    end
    checks++;
    if (tx_log.size() !== 1 || tx_log[0] !== 16'hD000) begin
      errors++;
      $display("FAIL bad_id_tx: got %0d words first=%h required 1 word d000",
               tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 16'hxxxx);
    end
    id_resp = 8'h58;
    n = 0;
    while (tx_log.size() < 3 && n < POW + 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (tx_log.size() < 3 || tx_log[1] !== 16'hD000 || tx_log[2] !== 16'h7500) begin
      errors++;
      $display("FAIL bad_id_retry: got %h %h required d000 7500",
               (tx_log.size() > 1) ? tx_log[1] : 16'hxxxx,
               (tx_log.size() > 2) ? tx_log[2] : 16'hxxxx);
    end
    checks++;
    if (id_ok !== 1'b1 || spi_error !== 1'b1) begin
      errors++;
      $display("FAIL bad_id_recover: got id_ok=%b spi_error=%b required 1 1", id_ok, spi_error);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) burst[i] = 8'h00;
    test_reset();
    test_bringup();
    test_sample();
    test_back_to_back();
    test_timeout();
    test_reset_mid_burst();
    test_bad_id();
    checks++;
    if (dv_no_id !== 0) begin
      errors++;
      $display("FAIL valid_before_id: got %0d strobes without id_ok required 0", dv_no_id);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bmp280_sequencer.md
Name: bmp280_sequencer

Overview:
- Transaction sequencer that sits directly upstream of the 16-bit SPI master and drives its `enable_spi`/`tx_byte` inputs.
- Bring-up sequence: checks the BMP280 chip ID, then writes the `config` and `ctrl_meas` registers.
- Sampling: periodically reads the six raw pressure/temperature bytes and assembles the 20-bit raw values.
- Publishes each sample with a one-cycle valid strobe for the downstream UART formatter.

Parameters:
- SAMPLE_CYCLES, 5000000: clk cycles between sample bursts (100 ms at 50 MHz).
- POWERUP_CYCLES, 100000: delay after reset before the first SPI transaction (2 ms).
- TIMEOUT_CYCLES, 1000: maximum clk cycles spi_busy may stay high per transaction.
- CTRL_MEAS_VAL, 8'h27: value written to register 0xF4 (osrs_t x1, osrs_p x1, normal mode).
- CONFIG_VAL, 8'h00: value written to register 0xF5.
- CHIP_ID, 8'h58: expected contents of register 0xD0.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- spi_enable  output  1  one-cycle start request to the SPI master.
- spi_tx  output  16  transaction word {cmd[7:0], wdata[7:0]}.
- spi_rx  input  16  word received from the SPI master; data byte is spi_rx[7:0].
- spi_busy  input  1  SPI master busy flag.
- press_raw  output  20  last assembled raw pressure.
- temp_raw  output  20  last assembled raw temperature.
- data_valid  output  1  one-cycle strobe; press_raw/temp_raw updated in the same cycle.
- id_ok  output  1  chip ID matched; sticky until reset.
- spi_error  output  1  sticky timeout/ID-mismatch flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; spi_tx = 16'h0000; state = PWR_WAIT; all counters 0.
- Reset mid-operation: immediately returns to PWR_WAIT with outputs cleared; any partially read bytes are discarded.
- Main FSM states: PWR_WAIT -> RD_ID -> WR_CFG -> WR_CTRL -> SAMPLE_WAIT -> RD_BURST -> PUBLISH -> SAMPLE_WAIT.
- PWR_WAIT: counts POWERUP_CYCLES, then goes to RD_ID.
- RD_ID: issues cmd 8'hD0.
  - On completion, if spi_rx[7:0] == CHIP_ID: set id_ok, go to WR_CFG.
  - Otherwise: set spi_error, return to PWR_WAIT (retry).
- WR_CFG: issues {8'h75, CONFIG_VAL}; write = register address with bit 7 cleared.
- WR_CTRL: issues {8'h74, CTRL_MEAS_VAL}, then goes to SAMPLE_WAIT.
- SAMPLE_WAIT:
  - Counts SAMPLE_CYCLES-1 down to 0; at 0 goes to RD_BURST.
  - The first burst after WR_CTRL also waits the full period.
- RD_BURST: six single-byte reads in order 8'hF7, F8, F9, FA, FB, FC, each tx word {addr, 8'h00}.
  - Byte index 0..5 increments on each completion.
  - Each byte is stored into a 6-byte shadow register.
- PUBLISH (one cycle):
  - press_raw = {b0, b1, b2[7:4]}; temp_raw = {b3, b4, b5[7:4]}.
  - data_valid = 1; next state SAMPLE_WAIT.
- Per-transaction handshake sub-FSM: ISSUE -> WAIT_BUSY_HI -> WAIT_BUSY_LO -> DONE.
  - ISSUE: entered only when spi_busy = 0. spi_tx is driven and spi_enable = 1 for exactly one cycle. spi_tx stays stable from ISSUE until DONE.
  - WAIT_BUSY_HI: waits up to 4 cycles for spi_busy = 1. Otherwise timeout.
  - WAIT_BUSY_LO: waits for spi_busy falling. spi_rx is sampled in the cycle busy is first observed low (DONE).
  - A busy-high counter exceeding TIMEOUT_CYCLES is a timeout.
- Timeout: set spi_error, abandon the burst without publishing, go to PWR_WAIT (full re-initialisation).
- If spi_busy is already high when ISSUE is entered, the sequencer waits in ISSUE without asserting spi_enable.
- data_valid never asserts before id_ok = 1.
- press_raw/temp_raw hold their values between strobes.
- Counters are sized by $clog2 of their parameter. The SAMPLE_WAIT counter reloads on entry.

Test Plan:
- Reset release, SPI model returns 8'h58 for 0xD0 -> after POWERUP_CYCLES, tx sequence observed is 16'hD000, 16'h7500, 16'h7427; id_ok = 1; spi_error = 0.
- Model returns bytes F7..FC = 8'h65, 8'h5A, 8'hC0, 8'h7E, 8'hED, 8'h00 -> single data_valid pulse; press_raw = 20'h655AC; temp_raw = 20'h7EED0.
- Chip ID returns 8'h60 -> spi_error = 1, id_ok = 0, no WR_CFG; sequencer restarts at PWR_WAIT and re-reads 0xD0.
- SPI model holds busy high for TIMEOUT_CYCLES+1 during the third burst read -> spi_error = 1, no data_valid, re-initialisation starts with 16'hD000.
- reset_n asserted mid-burst (after the 2nd byte) -> all outputs 0 immediately; after release, full sequence restarts.
- Two consecutive bursts with SAMPLE_CYCLES = 200 -> data_valid pulses spaced by 200 + burst duration cycles; spi_enable is never asserted while spi_busy = 1.
